// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin sharing of one RNG word source between several requesters,
// with a repetition-count health test and a response timeout that latch a sticky fault.
module rng_arbiter #(
   parameter int WIDTH       = 8,
   parameter int NUM_CLIENTS = 4,
   parameter int REP_LIMIT   = 4,
   parameter int TIMEOUT     = 64,
   localparam int IDW        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CLIENTS-1:0] cli_req,
   output logic [NUM_CLIENTS-1:0] cli_valid,
   output logic [WIDTH-1:0]       cli_word,
   output logic [IDW-1:0]         grant_id,
   output logic                   busy,
   output logic                   fault,
   output logic                   rng_en,
   output logic                   rng_req,
   input  logic [WIDTH-1:0]       rng_word,
   input  logic                   rng_valid
);
   localparam int REPW = $clog2(REP_LIMIT + 1);
   localparam int TOW  = $clog2(TIMEOUT + 1);

   // Handshakes: cli_req is a level held until its one-cycle cli_valid pulse;
   // rng_req is held through FETCH and rng_valid is a one-cycle pulse sampled only there.
   typedef enum logic [1:0] {IDLE, FETCH, DELIVER, FAULT} state_t;

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [REPW-1:0]  rep_cnt;
   logic [TOW-1:0]   to_cnt;
   logic [WIDTH-1:0] prev_word;
   logic             have_prev;
   logic             abandoned;

   logic [IDW-1:0]   pick;
   logic [REPW-1:0]  rep_next;
   logic             health_fail;
   logic             keep_word;

   // First requesting client at or above start, wrapping; the downward scan lets the
   // smallest offset win.
   function automatic logic [IDW-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                              input logic [IDW-1:0] start);
      logic [IDW-1:0] sel;
      int idx;
      sel = start;
      for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
         idx = (int'(start) + i) % NUM_CLIENTS;
         if (req[idx]) sel = IDW'(idx);
      end
      return sel;
   endfunction

   always_comb begin
      pick        = rr_pick(cli_req, rr_ptr);
      rep_next    = (have_prev && rng_word == prev_word) ? rep_cnt + REPW'(1) : REPW'(1);
      health_fail = (int'(rep_next) >= REP_LIMIT);
      keep_word   = !abandoned && cli_req[grant_id];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         rep_cnt   <= '0;
         to_cnt    <= '0;
         prev_word <= '0;
         have_prev <= 1'b0;
         abandoned <= 1'b0;
         cli_valid <= '0;
         cli_word  <= '0;
         grant_id  <= '0;
         busy      <= 1'b0;
         fault     <= 1'b0;
         rng_req   <= 1'b0;
         rng_en    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (|cli_req) begin
                  grant_id  <= pick;
                  rr_ptr    <= (int'(pick) == NUM_CLIENTS - 1) ? '0 : pick + IDW'(1);
                  to_cnt    <= '0;
                  abandoned <= 1'b0;
                  busy      <= 1'b1;
                  rng_req   <= 1'b1;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               if (rng_valid) begin
                  // Every captured word feeds the health test, delivered or not.
                  prev_word <= rng_word;
                  have_prev <= 1'b1;
                  rep_cnt   <= rep_next;
                  rng_req   <= 1'b0;
                  if (health_fail) begin
                     state  <= FAULT;
                     fault  <= 1'b1;
                     rng_en <= 1'b0;
                     busy   <= 1'b0;
                  end else begin
                     state <= DELIVER;
                     if (keep_word) begin
                        cli_valid <= NUM_CLIENTS'(1) << grant_id;
                        cli_word  <= rng_word;
                     end
                  end
               end else if (to_cnt == TOW'(TIMEOUT - 1)) begin
                  state   <= FAULT;
                  fault   <= 1'b1;
                  rng_en  <= 1'b0;
                  rng_req <= 1'b0;
                  busy    <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + TOW'(1);
                  if (!cli_req[grant_id]) abandoned <= 1'b1;
               end
            end
            DELIVER: begin
               cli_valid <= '0;
               cli_word  <= '0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            FAULT: begin
               state <= FAULT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: scenario tasks for rng_arbiter, checked against an integer-level
// model of round-robin order and the repetition-count rule.
module tb_rng_arbiter;
   localparam int W  = 8;
   localparam int NC = 4;
   localparam int RL = 4;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NC-1:0] cli_req = '0;
   logic [NC-1:0] cli_valid;
   logic [W-1:0]  cli_word;
   logic [1:0]    grant_id;
   logic          busy, fault, rng_en, rng_req;
   logic [W-1:0]  rng_word = '0;
   logic          rng_valid = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int           mdl_ptr;
   bit           mdl_have;
   logic [W-1:0] mdl_prev;
   int           mdl_rep;
   logic [W-1:0] exp_q[$];

   rng_arbiter #(.WIDTH(W), .NUM_CLIENTS(NC), .REP_LIMIT(RL), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .cli_req(cli_req), .cli_valid(cli_valid),
      .cli_word(cli_word), .grant_id(grant_id), .busy(busy), .fault(fault),
      .rng_en(rng_en), .rng_req(rng_req), .rng_word(rng_word), .rng_valid(rng_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      mdl_ptr  = 0;
      mdl_have = 0;
      mdl_prev = '0;
      mdl_rep  = 0;
      exp_q.delete();
   endtask

   // Client chosen from the request vector, advancing the pointer past it.
   task automatic model_grant(input logic [NC-1:0] req, output int g);
      g = -1;
      for (int i = 0; i < NC; i++) begin
         int c = (mdl_ptr + i) % NC;
         if (g < 0 && req[c]) g = c;
      end
      mdl_ptr = (g + 1) % NC;
   endtask

   task automatic model_health(input logic [W-1:0] word, output bit pass);
      if (mdl_have && word == mdl_prev) mdl_rep = mdl_rep + 1;
      else mdl_rep = 1;
      mdl_prev = word;
      mdl_have = 1;
      pass = (mdl_rep < RL);
   endtask

   task automatic apply_reset();
      reset     = 1'b1;
      cli_req   = '0;
      rng_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
      model_reset();
   endtask

   // Waits (bounded) for rng_req, waits delay cycles, pulses rng_valid, and returns
   // in the cycle after the pulse.
   task automatic rng_respond(input logic [W-1:0] word, input int delay, output bit seen);
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         if (rng_req === 1'b1) begin
            seen = 1;
            break;
         end
         step();
      end
      if (!seen) return;
      repeat (delay) step();
      rng_valid = 1'b1;
      rng_word  = word;
      step();
      rng_valid = 1'b0;
      rng_word  = '0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      cli_req   = '1;
      rng_valid = 1'b1;
      rng_word  = 8'hFF;
      step();
      step();
      checks++;
      if ({cli_valid, cli_word, grant_id, busy, fault, rng_req, rng_en} !== 18'd1) begin
         errors++;
         $display("FAIL reset_values got %b want %b",
                  {cli_valid, cli_word, grant_id, busy, fault, rng_req, rng_en}, 18'd1);
      end
      rng_valid = 1'b0;
      rng_word  = '0;
      cli_req   = '0;
      reset     = 1'b0;
      model_reset();
      step();
      checks++;
      if (busy !== 1'b0 || rng_req !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b rng_req=%b want 0 0", busy, rng_req);
      end
   endtask

   task automatic test_single();
      int t0;
      bit seen;
      apply_reset();
      cli_req = 4'b0001;
      t0 = cyc;
      step();
      checks++;
      if (rng_req !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL single_fetch got rng_req=%b busy=%b grant=%0d want 1 1 0", rng_req, busy, grant_id);
      end
      rng_respond(8'h5A, 1, seen);
      checks++;
      if (!seen || cli_valid !== 4'b0001 || cli_word !== 8'h5A || fault !== 1'b0) begin
         errors++;
         $display("FAIL single_deliver got seen=%0b valid=%b word=%h fault=%b want 1 0001 5a 0",
                  seen, cli_valid, cli_word, fault);
      end
      checks++;
      if (cyc - t0 !== 3) begin
         errors++;
         $display("FAIL single_latency got %0d want 3", cyc - t0);
      end
      checks++;
      if (rng_req !== 1'b0) begin
         errors++;
         $display("FAIL single_req_drop got %b want 0", rng_req);
      end
      cli_req = '0;
      step();
      checks++;
      if (cli_valid !== 4'b0000 || cli_word !== 8'h00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_idle got valid=%b word=%h busy=%b want 0000 00 0", cli_valid, cli_word, busy);
      end
   endtask

   task automatic test_rr_all();
      int order[6] = '{0, 1, 2, 3, 0, 1};
      bit seen;
      logic [NC-1:0] want;
      apply_reset();
      cli_req = 4'b1111;
      for (int n = 0; n < 6; n++) begin
         rng_respond(8'(8'h10 + n), $urandom_range(0, 3), seen);
         want = 4'b0001 << order[n];
         checks++;
         if (!seen || cli_valid !== want || cli_word !== 8'(8'h10 + n)) begin
            errors++;
            $display("FAIL rr_all[%0d] got valid=%b word=%h want %b %h", n, cli_valid, cli_word,
                     want, 8'(8'h10 + n));
         end
      end
      cli_req = '0;
      step();
   endtask

   task automatic test_rr_pointer();
      bit seen;
      apply_reset();
      cli_req = 4'b0100;
      rng_respond(8'h31, 0, seen);
      checks++;
      if (!seen || cli_valid !== 4'b0100) begin
         errors++;
         $display("FAIL rrp_client2 got %b want 0100", cli_valid);
      end
      cli_req = '0;
      step();
      cli_req = 4'b1010;
      step();
      checks++;
      if (grant_id !== 2'd3) begin
         errors++;
         $display("FAIL rrp_grant3 got %0d want 3", grant_id);
      end
      rng_respond(8'h32, 2, seen);
      checks++;
      if (!seen || cli_valid !== 4'b1000 || cli_word !== 8'h32) begin
         errors++;
         $display("FAIL rrp_client3 got %b %h want 1000 32", cli_valid, cli_word);
      end
      cli_req = 4'b0010;
      rng_respond(8'h33, 1, seen);
      checks++;
      if (!seen || cli_valid !== 4'b0010 || cli_word !== 8'h33) begin
         errors++;
         $display("FAIL rrp_client1 got %b %h want 0010 33", cli_valid, cli_word);
      end
      cli_req = '0;
      step();
   endtask

   task automatic test_rep_fault();
      bit seen;
      bit quiet;
      apply_reset();
      cli_req = 4'b0001;
      for (int n = 0; n < 3; n++) begin
         rng_respond(8'hAA, 1, seen);
         checks++;
         if (!seen || cli_valid !== 4'b0001 || cli_word !== 8'hAA) begin
            errors++;
            $display("FAIL rep_deliver[%0d] got %b %h want 0001 aa", n, cli_valid, cli_word);
         end
      end
      rng_respond(8'hAA, 1, seen);
      checks++;
      if (!seen || cli_valid !== 4'b0000 || fault !== 1'b1 || rng_en !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rep_trip got valid=%b fault=%b rng_en=%b busy=%b want 0000 1 0 0",
                  cli_valid, fault, rng_en, busy);
      end
      quiet = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (rng_req !== 1'b0 || cli_valid !== 4'b0000 || fault !== 1'b1) quiet = 0;
      end
      checks++;
      if (!quiet) begin
         errors++;
         $display("FAIL rep_sticky got quiet=%0b want 1", quiet);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({cli_valid, cli_word, grant_id, busy, fault, rng_req, rng_en} !== 18'd1) begin
         errors++;
         $display("FAIL rep_reset got %b want %b",
                  {cli_valid, cli_word, grant_id, busy, fault, rng_req, rng_en}, 18'd1);
      end
      apply_reset();
   endtask

   task automatic test_timeout();
      bit quiet;
      apply_reset();
      cli_req = 4'b0001;
      quiet = 1;
      for (int i = 0; i < TO; i++) begin
         step();
         if (cli_valid !== 4'b0000) quiet = 0;
      end
      checks++;
      if (!quiet || fault !== 1'b0 || rng_req !== 1'b1) begin
         errors++;
         $display("FAIL timeout_edge got quiet=%0b fault=%b rng_req=%b want 1 0 1", quiet, fault, rng_req);
      end
      step();
      checks++;
      if (fault !== 1'b1 || rng_en !== 1'b0 || rng_req !== 1'b0 || cli_valid !== 4'b0000) begin
         errors++;
         $display("FAIL timeout_fault got fault=%b rng_en=%b rng_req=%b valid=%b want 1 0 0 0000",
                  fault, rng_en, rng_req, cli_valid);
      end
      apply_reset();
   endtask

   task automatic test_reset_mid_fetch();
      bit seen;
      apply_reset();
      cli_req = 4'b0011;
      step();
      step();
      step();
      checks++;
      if (busy !== 1'b1 || rng_req !== 1'b1) begin
         errors++;
         $display("FAIL midfetch_busy got busy=%b rng_req=%b want 1 1", busy, rng_req);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({cli_valid, cli_word, grant_id, busy, fault, rng_req, rng_en} !== 18'd1) begin
         errors++;
         $display("FAIL midfetch_reset got %b want %b",
                  {cli_valid, cli_word, grant_id, busy, fault, rng_req, rng_en}, 18'd1);
      end
      reset = 1'b0;
      model_reset();
      step();
      checks++;
      if (grant_id !== 2'd0) begin
         errors++;
         $display("FAIL midfetch_ptr got %0d want 0", grant_id);
      end
      rng_respond(8'h42, 0, seen);
      checks++;
      if (!seen || cli_valid !== 4'b0001 || cli_word !== 8'h42) begin
         errors++;
         $display("FAIL midfetch_deliver got %b %h want 0001 42", cli_valid, cli_word);
      end
      cli_req = '0;
      step();
   endtask

   task automatic test_drop();
      bit seen;
      apply_reset();
      cli_req = 4'b0011;
      step();
      cli_req[0] = 1'b0;
      rng_respond(8'h77, 2, seen);
      checks++;
      if (!seen || cli_valid !== 4'b0000 || fault !== 1'b0) begin
         errors++;
         $display("FAIL drop_discard got valid=%b fault=%b want 0000 0", cli_valid, fault);
      end
      for (int n = 0; n < 2; n++) begin
         rng_respond(8'h77, 1, seen);
         checks++;
         if (!seen || cli_valid !== 4'b0010 || cli_word !== 8'h77) begin
            errors++;
            $display("FAIL drop_next[%0d] got %b %h want 0010 77", n, cli_valid, cli_word);
         end
      end
      rng_respond(8'h77, 1, seen);
      checks++;
      if (!seen || fault !== 1'b1 || cli_valid !== 4'b0000) begin
         errors++;
         $display("FAIL drop_counted got fault=%b valid=%b want 1 0000", fault, cli_valid);
      end
      apply_reset();
   endtask

   task automatic test_random();
      logic [NC-1:0] req;
      logic [W-1:0]  word;
      logic [NC-1:0] want_v;
      logic [W-1:0]  want_w;
      int g;
      bit seen, pass, drop;
      apply_reset();
      for (int n = 0; n < 40; n++) begin
         req     = NC'($urandom_range(1, 15));
         cli_req = req;
         model_grant(req, g);
         step();
         checks++;
         if (grant_id !== 2'(g)) begin
            errors++;
            $display("FAIL rand_grant[%0d] got %0d want %0d", n, grant_id, g);
         end
         drop = ($urandom_range(0, 4) == 0);
         if (drop) cli_req[g] = 1'b0;
         word = W'($urandom_range(0, 2));
         rng_respond(word, $urandom_range(0, 5), seen);
         model_health(word, pass);
         if (!pass) begin
            checks++;
            if (!seen || fault !== 1'b1 || cli_valid !== 4'b0000) begin
               errors++;
               $display("FAIL rand_fault[%0d] got fault=%b valid=%b want 1 0000", n, fault, cli_valid);
            end
            apply_reset();
         end else begin
            want_v = '0;
            if (!drop) begin
               want_v = 4'b0001 << g;
               exp_q.push_back(word);
            end
            want_w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (!seen || cli_valid !== want_v || cli_word !== want_w || fault !== 1'b0) begin
               errors++;
               $display("FAIL rand_deliver[%0d] got valid=%b word=%h fault=%b want %b %h 0",
                        n, cli_valid, cli_word, fault, want_v, want_w);
            end
            cli_req = '0;
            step();
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr_all();
      test_rr_pointer();
      test_rep_fault();
      test_timeout();
      test_reset_mid_fetch();
      test_drop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
